// File: rtl/fe25519_pkg.sv
// Shared Curve25519 field definitions: prime, ladder constant, field element type,
// sequencer states and the combinational modular add/sub used by the ladder datapath.
package fe25519_pkg;

    localparam int W = 255;

    typedef logic [W-1:0] fe_t;

    localparam fe_t P         = {{250{1'b1}}, 5'b01101};  // 2^255 - 19
    localparam fe_t P_MINUS_2 = P - fe_t'(2);
    localparam fe_t A24       = fe_t'(121665);

    // Last micro-op of a ladder step (op 0 is the swap/prepare cycle, 1..10 are mul/sqr).
    localparam logic [3:0] OP_LAST = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LADDER,
        S_FINAL_SWAP,
        S_INVERT,
        S_OUT_MUL,
        S_DONE
    } state_t;

    function automatic fe_t fe_reduce(input fe_t a);
        return (a >= P) ? a - P : a;
    endfunction

    function automatic fe_t fe_add(input fe_t a, input fe_t b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[W-1:0];
    endfunction

    // a - b, wrapped back into range by adding p when a < b.
    function automatic fe_t fe_sub(input fe_t a, input fe_t b);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (a < b) d = d + {1'b0, P};
        return d[W-1:0];
    endfunction

endpackage

// File: rtl/fe_mul.sv
// Sequential modular multiplier mod 2^255-19: MSB-first interleaved shift-add,
// one multiplier bit per cycle with conditional subtraction of p after each doubling and add.
module fe_mul
    import fe25519_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  fe_t  a,
    input  fe_t  b,
    output fe_t  y,
    output logic busy,
    output logic done
);

    // Handshake: start is accepted only while busy is low; busy stays high for exactly
    // 255 cycles; done pulses for one cycle when y = a*b mod p, and y holds until the next start.
    localparam logic [W:0] P_EXT = {1'b0, P};

    fe_t        a_q, b_q, acc, acc_nxt;
    logic [7:0] cnt;
    logic [W:0] dbl, dbl_r, sum;

    always_comb begin
        dbl     = {acc, 1'b0};
        dbl_r   = (dbl >= P_EXT) ? dbl - P_EXT : dbl;
        sum     = dbl_r + (b_q[W-1] ? {1'b0, a_q} : '0);
        acc_nxt = fe_t'((sum >= P_EXT) ? sum - P_EXT : sum);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q  <= '0;
            b_q  <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                a_q  <= a;
                b_q  <= b;
                acc  <= '0;
                cnt  <= 8'd254;
                busy <= 1'b1;
            end else if (busy) begin
                acc <= acc_nxt;
                b_q <= b_q << 1;
                if (cnt == 8'd0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt - 8'd1;
                end
            end
        end
    end

    assign y = acc;

endmodule

// File: rtl/scalar_multiplication.sv
// X25519-style x-only Montgomery ladder on Curve25519 with Fermat inversion; self-starting
// after reset release, fixed latency independent of k and x_p, sticky result.
module scalar_multiplication
    import fe25519_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  fe_t    k,
    input  fe_t    x_p,
    output fe_t    x_q,
    output logic   done,
    output state_t dbg_state
);

    state_t     state, state_nxt;
    fe_t        k_q, x1, x2, z2, x3, z3;
    fe_t        ta, tb, tc, td, aa, bb, da, cb;
    logic       swap, issued;
    logic [7:0] bit_idx;
    logic [3:0] op;

    logic       need_mul, mul_start, mul_busy, mul_done;
    fe_t        mul_a, mul_b, mul_y;

    logic       sw, inv_last;
    fe_t        sx2, sz2, sx3, sz3, e_val;

    // The cswap is a plain mux on the combined swap bit, so every step costs the same cycles.
    assign sw       = swap ^ k_q[bit_idx];
    assign sx2      = sw ? x3 : x2;
    assign sz2      = sw ? z3 : z2;
    assign sx3      = sw ? x2 : x3;
    assign sz3      = sw ? z2 : z3;
    assign e_val    = fe_sub(aa, bb);
    assign inv_last = (op == 4'd1) || !P_MINUS_2[bit_idx];
    assign dbg_state = state;

    fe_mul u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .y     (mul_y),
        .busy  (mul_busy),
        .done  (mul_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       state_nxt = S_LOAD;
            S_LOAD:       state_nxt = S_LADDER;
            S_LADDER:     if (mul_done && op == OP_LAST && bit_idx == 8'd0) state_nxt = S_FINAL_SWAP;
            S_FINAL_SWAP: state_nxt = S_INVERT;
            S_INVERT:     if (mul_done && inv_last && bit_idx == 8'd0) state_nxt = S_OUT_MUL;
            S_OUT_MUL:    if (mul_done) state_nxt = S_DONE;
            default:      state_nxt = state;
        endcase
    end

    always_comb begin
        need_mul = 1'b0;
        mul_a    = '0;
        mul_b    = '0;
        case (state)
            S_LADDER: begin
                need_mul = (op != 4'd0);
                case (op)
                    4'd1:  begin mul_a = ta;  mul_b = ta; end
                    4'd2:  begin mul_a = tb;  mul_b = tb; end
                    4'd3:  begin mul_a = td;  mul_b = ta; end
                    4'd4:  begin mul_a = tc;  mul_b = tb; end
                    4'd5:  begin mul_a = fe_add(da, cb); mul_b = fe_add(da, cb); end
                    4'd6:  begin mul_a = fe_sub(da, cb); mul_b = fe_sub(da, cb); end
                    4'd7:  begin mul_a = x1;  mul_b = tc; end
                    4'd8:  begin mul_a = aa;  mul_b = bb; end
                    4'd9:  begin mul_a = A24; mul_b = e_val; end
                    4'd10: begin mul_a = e_val; mul_b = fe_add(aa, tc); end
                    default: ;
                endcase
            end
            S_INVERT: begin
                need_mul = 1'b1;
                mul_a    = ta;
                mul_b    = (op == 4'd0) ? ta : z2;
            end
            S_OUT_MUL: begin
                need_mul = 1'b1;
                mul_a    = x2;
                mul_b    = ta;
            end
            default: ;
        endcase
        mul_start = need_mul && !issued && !mul_busy;
        done      = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q <= '0; x1 <= '0; x2 <= '0; z2 <= '0; x3 <= '0; z3 <= '0;
            ta  <= '0; tb <= '0; tc <= '0; td <= '0;
            aa  <= '0; bb <= '0; da <= '0; cb <= '0;
            x_q <= '0;
            swap    <= 1'b0;
            issued  <= 1'b0;
            bit_idx <= '0;
            op      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    k_q <= k;
                    x1  <= x_p;
                end
                S_LOAD: begin
                    x1      <= fe_reduce(x1);
                    x2      <= fe_t'(1);
                    z2      <= '0;
                    x3      <= fe_reduce(x1);
                    z3      <= fe_t'(1);
                    swap    <= 1'b0;
                    bit_idx <= 8'd254;
                    op      <= '0;
                end
                S_LADDER: begin
                    if (op == 4'd0) begin
                        x2   <= sx2;
                        z2   <= sz2;
                        x3   <= sx3;
                        z3   <= sz3;
                        ta   <= fe_add(sx2, sz2);
                        tb   <= fe_sub(sx2, sz2);
                        tc   <= fe_add(sx3, sz3);
                        td   <= fe_sub(sx3, sz3);
                        swap <= k_q[bit_idx];
                        op   <= 4'd1;
                    end else if (mul_done) begin
                        case (op)
                            4'd1:    aa <= mul_y;
                            4'd2:    bb <= mul_y;
                            4'd3:    da <= mul_y;
                            4'd4:    cb <= mul_y;
                            4'd5:    x3 <= mul_y;
                            4'd6:    tc <= mul_y;
                            4'd7:    z3 <= mul_y;
                            4'd8:    x2 <= mul_y;
                            4'd9:    tc <= mul_y;
                            default: z2 <= mul_y;
                        endcase
                        if (op == OP_LAST) begin
                            op <= '0;
                            if (bit_idx != 8'd0) bit_idx <= bit_idx - 8'd1;
                        end else begin
                            op <= op + 4'd1;
                        end
                    end
                end
                S_FINAL_SWAP: begin
                    // Exponent bit 254 is set, so the power starts at z2 and resumes from bit 253.
                    x2      <= swap ? x3 : x2;
                    z2      <= swap ? z3 : z2;
                    ta      <= swap ? z3 : z2;
                    bit_idx <= 8'd253;
                    op      <= '0;
                end
                S_INVERT: begin
                    if (mul_done) begin
                        ta <= mul_y;
                        if (inv_last) begin
                            op <= '0;
                            if (bit_idx != 8'd0) bit_idx <= bit_idx - 8'd1;
                        end else begin
                            op <= 4'd1;
                        end
                    end
                end
                S_OUT_MUL: begin
                    if (mul_done) x_q <= mul_y;
                end
                default: ;
            endcase

            if (mul_start)     issued <= 1'b1;
            else if (mul_done) issued <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scalar_multiplication.sv
// Bench for scalar_multiplication: directed and random scalars checked against an
// arithmetic X25519 reference model, constant latency, sticky result and async abort.
module tb_scalar_multiplication;
    import fe25519_pkg::*;

    localparam int MAX_CYCLES = 1_000_000;
    localparam logic [255:0] TWO_255 = 256'd1 << 255;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    fe_t    k   = '0;
    fe_t    x_p = '0;
    fe_t    x_q;
    logic   done;
    state_t dbg_state;

    int     n_checks = 0;
    int     n_errors = 0;
    logic [254:0] exp_q[$];

    fe_t    p_ref;
    fe_t    a24_ref;

    scalar_multiplication dut (
        .clk       (clk),
        .rst       (rst),
        .k         (k),
        .x_p       (x_p),
        .x_q       (x_q),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input fe_t got, input fe_t expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic fe_t m_mul(input fe_t a, input fe_t b);
        logic [511:0] prod;
        prod = {257'd0, a} * {257'd0, b};
        return fe_t'(prod % {257'd0, p_ref});
    endfunction

    function automatic fe_t m_add(input fe_t a, input fe_t b);
        logic [255:0] s;
        s = {1'b0, a} + {1'b0, b};
        return fe_t'(s % {1'b0, p_ref});
    endfunction

    function automatic fe_t m_sub(input fe_t a, input fe_t b);
        return m_add(a, p_ref - b);
    endfunction

    function automatic fe_t m_pow(input fe_t base, input fe_t e);
        fe_t r = fe_t'(1);
        fe_t b = base;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = m_mul(r, b);
            b = m_mul(b, b);
        end
        return r;
    endfunction

    function automatic fe_t ref_x25519(input fe_t kk, input fe_t xp);
        fe_t x1, x2, z2, x3, z3, tmp;
        fe_t a, aa, b, bb, e, c, d, da, cb;
        logic sw, kt;
        logic [255:0] xw;
        xw = {1'b0, xp} % {1'b0, p_ref};
        x1 = fe_t'(xw);
        x2 = fe_t'(1); z2 = '0; x3 = x1; z3 = fe_t'(1); sw = 1'b0;
        for (int t = W - 1; t >= 0; t--) begin
            kt = kk[t];
            sw = sw ^ kt;
            if (sw) begin
                tmp = x2; x2 = x3; x3 = tmp;
                tmp = z2; z2 = z3; z3 = tmp;
            end
            sw = kt;
            a  = m_add(x2, z2); aa = m_mul(a, a);
            b  = m_sub(x2, z2); bb = m_mul(b, b);
            e  = m_sub(aa, bb);
            c  = m_add(x3, z3); d = m_sub(x3, z3);
            da = m_mul(d, a);   cb = m_mul(c, b);
            x3 = m_mul(m_add(da, cb), m_add(da, cb));
            z3 = m_mul(x1, m_mul(m_sub(da, cb), m_sub(da, cb)));
            x2 = m_mul(aa, bb);
            z2 = m_mul(e, m_add(aa, m_mul(a24_ref, e)));
        end
        if (sw) begin
            x2 = x3;
            z2 = z3;
        end
        return m_mul(x2, m_pow(z2, p_ref - fe_t'(2)));
    endfunction

    function automatic fe_t rand_fe();
        fe_t r = '0;
        for (int i = 0; i < 8; i++) r = (r << 32) | fe_t'($urandom);
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic run_case(input string tag, input fe_t k_in, input fe_t x_in, output int cycles);
        fe_t expv;
        k   = k_in;
        x_p = x_in;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cycles = 1;
        // Inputs were latched on the first edge; anything after that must be ignored.
        k   = rand_fe();
        x_p = rand_fe();
        while (!done && cycles < MAX_CYCLES) begin
            @(negedge clk);
            cycles++;
        end
        expv = exp_q.pop_front();
        check({tag, " done"}, fe_t'(done), fe_t'(1));
        check({tag, " x_q"}, x_q, expv);
        repeat (5) @(negedge clk);
        check({tag, " hold x_q"}, x_q, expv);
        check({tag, " hold done"}, fe_t'(done), fe_t'(1));
        $display("%s latency %0d cycles", tag, cycles);
    endtask

    initial begin
        int   c_ref, c;
        int   waited;
        fe_t  kr, xr;
        fe_t  k_big, x_big, exp_k2;

        p_ref   = fe_t'(TWO_255 - 256'd19);
        a24_ref = fe_t'(121665);
        k_big   = 255'd45965849458578823337285628114947185621072782472466027602082789798859530730302;
        x_big   = 255'd51787047396206507371575496351547757668573928710407442995900366718792724607247;
        exp_k2  = 255'd14847277145635483483963372537557091634710985132825781088887140890597596352251;

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset x_q", x_q, '0);
        check("reset done", fe_t'(done), '0);
        check("reset state", fe_t'(dbg_state), fe_t'(S_IDLE));

        exp_q.push_back(fe_t'(9));
        run_case("k=1 x=9", fe_t'(1), fe_t'(9), c_ref);
        check("latency bound", fe_t'(c_ref < MAX_CYCLES), fe_t'(1));

        exp_q.push_back('0);
        run_case("k=0 x=9", '0, fe_t'(9), c);
        check("latency k=0", fe_t'(c), fe_t'(c_ref));

        exp_q.push_back(exp_k2);
        run_case("k=2 x=9", fe_t'(2), fe_t'(9), c);
        check("latency k=2", fe_t'(c), fe_t'(c_ref));

        exp_q.push_back(ref_x25519(k_big, x_big));
        run_case("big vector", k_big, x_big, c);
        check("latency big", fe_t'(c), fe_t'(c_ref));

        // Reset from DONE must clear outputs asynchronously.
        #2 rst = 1'b0;
        #1;
        check("abort done x_q", x_q, '0);
        check("abort done flag", fe_t'(done), '0);

        exp_q.push_back(fe_t'(9));
        run_case("x=p+9 k=1", fe_t'(1), p_ref + fe_t'(9), c);
        check("latency p+9", fe_t'(c), fe_t'(c_ref));

        // Mid-ladder abort, then restart from fresh inputs.
        k   = rand_fe();
        x_p = rand_fe();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        waited = 0;
        while (dbg_state != S_LADDER && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        repeat ($urandom_range(20000, 3000)) @(negedge clk);
        check("mid ladder state", fe_t'(dbg_state), fe_t'(S_LADDER));
        #2 rst = 1'b0;
        #1;
        check("mid abort done", fe_t'(done), '0);
        check("mid abort x_q", x_q, '0);
        check("mid abort state", fe_t'(dbg_state), fe_t'(S_IDLE));

        kr = rand_fe();
        xr = rand_fe();
        exp_q.push_back(ref_x25519(kr, xr));
        run_case("random after abort", kr, xr, c);
        check("latency random", fe_t'(c), fe_t'(c_ref));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
